// File: rtl/bolme_denetleyici.sv
// Iterative restoring divider sequencer for DIV/DIVU/REM/REMU: one quotient bit
// per cycle, RISC-V divide-by-zero/overflow rules, result held until acknowledged.
module bolme_denetleyici #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            istek_gecerli_i,
    output logic            istek_hazir_o,
    input  logic [1:0]      islem_i,
    input  logic [XLEN-1:0] bolunen_i,
    input  logic [XLEN-1:0] bolen_i,
    input  logic            iptal_i,
    output logic            sonuc_gecerli_o,
    output logic [XLEN-1:0] sonuc_o,
    input  logic            sonuc_alindi_i,
    output logic            durdur_o
);

    localparam int unsigned SAYAC_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        DUZELT  = 2'd2,
        BITTI   = 2'd3
    } durum_t;

    durum_t              durum;
    logic [SAYAC_W-1:0]  sayac;
    logic                kalan_mod;
    logic                negq;
    logic                negr;
    logic [XLEN-1:0]     q_r;
    logic [XLEN-1:0]     d_r;
    logic [XLEN-1:0]     r_r;

    logic                isaretli;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mutlak;
    logic [XLEN-1:0]     b_mutlak;
    logic                sifira_bolme;
    logic                tasma;
    logic [XLEN-1:0]     ozel_sonuc;
    logic                kabul;
    logic [XLEN:0]       t_deger;
    logic                buyuk_esit;
    logic [XLEN-1:0]     fark;
    logic [XLEN-1:0]     q_duz;
    logic [XLEN-1:0]     r_duz;

    always_comb begin
        isaretli     = ~islem_i[0];
        a_neg        = isaretli & bolunen_i[XLEN-1];
        b_neg        = isaretli & bolen_i[XLEN-1];
        a_mutlak     = a_neg ? -bolunen_i : bolunen_i;
        b_mutlak     = b_neg ? -bolen_i : bolen_i;
        sifira_bolme = (bolen_i == '0);
        tasma        = isaretli && (bolunen_i == {1'b1, {(XLEN-1){1'b0}}}) && (bolen_i == '1);
        if (sifira_bolme) begin
            ozel_sonuc = islem_i[1] ? bolunen_i : '1;
        end else begin
            ozel_sonuc = islem_i[1] ? '0 : bolunen_i;
        end
        kabul = (durum == BOSTA) && istek_gecerli_i && !iptal_i;
    end

    // The partial remainder always stays below D, so it fits in XLEN bits and the
    // subtraction can be done modulo 2^XLEN once the full-width compare has passed.
    always_comb begin
        t_deger    = {r_r, q_r[XLEN-1]};
        buyuk_esit = (t_deger >= {1'b0, d_r});
        fark       = t_deger[XLEN-1:0] - d_r;
        q_duz      = negq ? -q_r : q_r;
        r_duz      = negr ? -r_r : r_r;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum           <= BOSTA;
            sayac           <= '0;
            kalan_mod       <= 1'b0;
            negq            <= 1'b0;
            negr            <= 1'b0;
            q_r             <= '0;
            d_r             <= '0;
            r_r             <= '0;
            sonuc_o         <= '0;
            sonuc_gecerli_o <= 1'b0;
        end else if (iptal_i && (durum != BOSTA)) begin
            durum           <= BOSTA;
            sonuc_gecerli_o <= 1'b0;
        end else begin
            case (durum)
                BOSTA: begin
                    if (kabul) begin
                        kalan_mod <= islem_i[1];
                        negq      <= a_neg ^ b_neg;
                        negr      <= a_neg;
                        if (sifira_bolme || tasma) begin
                            sonuc_o         <= ozel_sonuc;
                            sonuc_gecerli_o <= 1'b1;
                            durum           <= BITTI;
                        end else begin
                            q_r   <= a_mutlak;
                            d_r   <= b_mutlak;
                            r_r   <= '0;
                            sayac <= SAYAC_W'(XLEN - 1);
                            durum <= HESAPLA;
                        end
                    end
                end
                HESAPLA: begin
                    r_r   <= buyuk_esit ? fark : t_deger[XLEN-1:0];
                    q_r   <= {q_r[XLEN-2:0], buyuk_esit};
                    sayac <= sayac - SAYAC_W'(1);
                    if (sayac == '0) begin
                        durum <= DUZELT;
                    end
                end
                DUZELT: begin
                    sonuc_o         <= kalan_mod ? r_duz : q_duz;
                    sonuc_gecerli_o <= 1'b1;
                    durum           <= BITTI;
                end
                BITTI: begin
                    if (sonuc_alindi_i) begin
                        durum           <= BOSTA;
                        sonuc_gecerli_o <= 1'b0;
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end

    assign istek_hazir_o = (durum == BOSTA);

    always_comb begin
        durdur_o = 1'b0;
        case (durum)
            HESAPLA, DUZELT: durdur_o = 1'b1;
            BITTI:           durdur_o = !sonuc_alindi_i;
            BOSTA:           durdur_o = istek_gecerli_i && !iptal_i;
            default:         durdur_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_bolme_denetleyici.sv
// Bench for bolme_denetleyici: cycle-level behavioural model plus directed
// divide/abort/hold scenarios with hand-computed results.
module tb_bolme_denetleyici;

    logic        clk = 1'b0;
    logic        rst;
    logic        istek_gecerli;
    logic        istek_hazir;
    logic [1:0]  islem;
    logic [31:0] bolunen;
    logic [31:0] bolen;
    logic        iptal;
    logic        sonuc_gecerli;
    logic [31:0] sonuc;
    logic        sonuc_alindi;
    logic        durdur;

    int vectors     = 0;
    int miscompares = 0;
    bit kontrol_aktif = 1'b0;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    always #5 clk = ~clk;

    bolme_denetleyici #(.XLEN(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .istek_gecerli_i (istek_gecerli),
        .istek_hazir_o   (istek_hazir),
        .islem_i         (islem),
        .bolunen_i       (bolunen),
        .bolen_i         (bolen),
        .iptal_i         (iptal),
        .sonuc_gecerli_o (sonuc_gecerli),
        .sonuc_o         (sonuc),
        .sonuc_alindi_i  (sonuc_alindi),
        .durdur_o        (durdur)
    );

    function automatic logic [31:0] beklenen_sonuc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic isaretli;
        isaretli = !op[0];
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (isaretli && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
        if (isaretli) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return op[1] ? a % b : a / b;
    endfunction

    function automatic bit ozel_durum(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: 0 idle, 1 computing (countdown to result), 2 holding result
    int          m_durum;
    int          m_kalan;
    logic        m_gecerli;
    logic [31:0] m_sonuc;
    logic [31:0] m_bekleyen;

    always @(posedge clk) begin
        if (rst) begin
            m_durum   <= 0;
            m_gecerli <= 1'b0;
            m_sonuc   <= 32'd0;
        end else if (m_durum != 0 && iptal) begin
            m_durum   <= 0;
            m_gecerli <= 1'b0;
        end else begin
            case (m_durum)
                0: if (istek_gecerli && !iptal) begin
                    if (ozel_durum(islem, bolunen, bolen)) begin
                        m_durum   <= 2;
                        m_gecerli <= 1'b1;
                        m_sonuc   <= beklenen_sonuc(islem, bolunen, bolen);
                    end else begin
                        m_durum    <= 1;
                        m_kalan    <= 33;
                        m_bekleyen <= beklenen_sonuc(islem, bolunen, bolen);
                    end
                end
                1: begin
                    m_kalan <= m_kalan - 1;
                    if (m_kalan == 1) begin
                        m_durum   <= 2;
                        m_gecerli <= 1'b1;
                        m_sonuc   <= m_bekleyen;
                    end
                end
                default: if (sonuc_alindi) begin
                    m_durum   <= 0;
                    m_gecerli <= 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic e_durdur;
        logic e_hazir;
        if (kontrol_aktif) begin
            e_hazir  = (m_durum == 0);
            e_durdur = (m_durum == 1) || (m_durum == 2 && !sonuc_alindi) ||
                       (m_durum == 0 && istek_gecerli && !iptal);
            vectors++;
            if ({istek_hazir, sonuc_gecerli, durdur, sonuc} !== {e_hazir, m_gecerli, e_durdur, m_sonuc}) begin
                miscompares++;
                $display("FAIL model t=%0t hazir/gecerli/durdur/sonuc got %b/%b/%b/%h want %b/%b/%b/%h",
                         $time, istek_hazir, sonuc_gecerli, durdur, sonuc, e_hazir, m_gecerli, e_durdur, m_sonuc);
            end
        end
    end

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        vectors++;
        if (gercek !== beklenen) begin
            miscompares++;
            $display("FAIL %s got %h want %h", ad, gercek, beklenen);
        end
    endtask

    // Called at posedge+1 with the block idle; returns with the result held.
    task automatic islem_yap(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] beklenen, input int bek_gecikme, input int bekle);
        int cyc;
        islem = op; bolunen = a; bolen = b; istek_gecerli = 1'b1;
        @(posedge clk); #1;
        istek_gecerli = 1'b0;
        bolunen = ~a; bolen = b ^ 32'h5A5A_0001; islem = ~op;
        cyc = 1;
        while (!sonuc_gecerli && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        kontrol("gecikme", 32'(cyc), 32'(bek_gecikme));
        kontrol("sonuc", sonuc, beklenen);
        for (int i = 0; i < bekle; i++) begin
            kontrol("tutma_sonuc", sonuc, beklenen);
            kontrol("tutma_durdur", {31'd0, durdur}, 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic onayla();
        sonuc_alindi = 1'b1;
        @(posedge clk); #1;
        sonuc_alindi = 1'b0;
    endtask

    initial begin
        int yukselme;
        rst = 1'b1; istek_gecerli = 1'b0; islem = 2'b00; bolunen = '0; bolen = '0;
        iptal = 1'b0; sonuc_alindi = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        kontrol_aktif = 1'b1;
        kontrol("reset_hazir", {31'd0, istek_hazir}, 32'd1);
        kontrol("reset_gecerli", {31'd0, sonuc_gecerli}, 32'd0);
        kontrol("reset_sonuc", sonuc, 32'd0);
        kontrol("reset_durdur", {31'd0, durdur}, 32'd0);

        islem_yap(DIVU, 32'd100, 32'd7, 32'd14, 34, 2);                         onayla();
        islem_yap(REMU, 32'd100, 32'd7, 32'd2, 34, 1);                          onayla();
        islem_yap(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);            onayla();
        islem_yap(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);            onayla();
        islem_yap(REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);                    onayla();
        islem_yap(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1);                     onayla();
        islem_yap(REMU, 32'd5, 32'd0, 32'd5, 1, 1);                             onayla();
        islem_yap(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);     onayla();
        islem_yap(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);             onayla();

        // Flush in the middle of an iteration
        islem = DIVU; bolunen = 32'd1000; bolen = 32'd3; istek_gecerli = 1'b1;
        @(posedge clk); #1 istek_gecerli = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        iptal = 1'b1;
        @(posedge clk); #1 iptal = 1'b0;
        kontrol("iptal_hazir", {31'd0, istek_hazir}, 32'd1);
        yukselme = 0;
        for (int i = 0; i < 40; i++) begin
            if (sonuc_gecerli) yukselme++;
            @(posedge clk); #1;
        end
        kontrol("iptal_gecerli_yok", 32'(yukselme), 32'd0);

        // Reset in the middle of an iteration
        islem = REMU; bolunen = 32'd1000; bolen = 32'd3; istek_gecerli = 1'b1;
        @(posedge clk); #1 istek_gecerli = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        kontrol("rst_hazir", {31'd0, istek_hazir}, 32'd1);
        kontrol("rst_gecerli", {31'd0, sonuc_gecerli}, 32'd0);
        kontrol("rst_sonuc", sonuc, 32'd0);
        kontrol("rst_durdur", {31'd0, durdur}, 32'd0);

        // Request together with flush while idle
        islem = DIVU; bolunen = 32'd9; bolen = 32'd3; istek_gecerli = 1'b1; iptal = 1'b1;
        @(posedge clk); #1;
        istek_gecerli = 1'b0; iptal = 1'b0;
        kontrol("iptal_kabul_yok", {31'd0, istek_hazir}, 32'd1);
        repeat (2) begin @(posedge clk); #1; end

        // Held result, then a request overlapping the acknowledge cycle
        islem_yap(DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34, 5);
        sonuc_alindi = 1'b1; islem = DIVU; bolunen = 32'd100; bolen = 32'd7; istek_gecerli = 1'b1;
        @(posedge clk); #1 sonuc_alindi = 1'b0;
        kontrol("onay_sonrasi_hazir", {31'd0, istek_hazir}, 32'd1);
        kontrol("onay_sonuc_korunur", sonuc, 32'h0FFF_FFFF);
        islem_yap(DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
        onayla();
        repeat (2) begin @(posedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
